// File: rtl/lgv8_br_pkg.sv
// Shared types for LEGv8 branch resolution and NZCV flag handling.
package lgv8_br_pkg;

  // LEGv8 condition codes, encoded as in the B.cond instruction field
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

  // Branch flavours decoded in ID
  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_kind_t;

  // Bit positions inside the packed {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // IDLE resolves branches; WAIT holds a B.cond until its flags are architectural
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fcu_state_t;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational LEGv8 condition evaluator: condition code + NZCV -> taken.
module cond_eval
  import lgv8_br_pkg::*;
(
  input  cond_t       cond,
  input  logic [3:0]  flags,
  output logic        taken
);

  logic n_bit;
  logic z_bit;
  logic c_bit;
  logic v_bit;

  assign n_bit = flags[FLAG_N];
  assign z_bit = flags[FLAG_Z];
  assign c_bit = flags[FLAG_C];
  assign v_bit = flags[FLAG_V];

  // Condition table; AL and NV both mean "always"
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z_bit;
      COND_NE: taken = !z_bit;
      COND_HS: taken = c_bit;
      COND_LO: taken = !c_bit;
      COND_MI: taken = n_bit;
      COND_PL: taken = !n_bit;
      COND_VS: taken = v_bit;
      COND_VC: taken = !v_bit;
      COND_HI: taken = c_bit & !z_bit;
      COND_LS: taken = !(c_bit & !z_bit);
      COND_GE: taken = (n_bit == v_bit);
      COND_LT: taken = (n_bit != v_bit);
      COND_GT: taken = !z_bit & (n_bit == v_bit);
      COND_LE: taken = !(!z_bit & (n_bit == v_bit));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// NZCV flags register plus ID-stage branch resolution, with either an EX->ID
// flag bypass (FWD_EX=1) or a one-cycle stall on a flag-setting EX instruction.
module flag_cond_unit
  import lgv8_br_pkg::*;
#(
  parameter int FWD_EX = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_set_flags,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry_out,
  input  logic        id_br_valid,
  input  logic [1:0]  id_br_kind,
  input  logic [3:0]  id_cond,
  input  logic        id_rt_zero,
  input  logic        flush,
  output logic        br_resolved,
  output logic        br_taken,
  output logic        stall,
  output logic [3:0]  flags_q
);

  fcu_state_t state_reg;
  fcu_state_t state_next;
  logic [3:0] flags_reg;
  logic [3:0] alu_flags;
  logic [3:0] flags_eff;
  logic       post_reset_reg;
  logic       flag_wr;
  logic       need_stall;
  logic       cond_taken;
  logic       kind_taken;
  br_kind_t   kind;

  assign kind    = br_kind_t'(id_br_kind);
  assign flag_wr = ex_valid & ex_set_flags;

  // Pack live ALU status into the {N,Z,C,V} layout of the flags register
  always_comb begin
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = alu_negative;
    alu_flags[FLAG_Z] = alu_zero;
    alu_flags[FLAG_C] = alu_carry_out;
    alu_flags[FLAG_V] = alu_overflow;
  end

  // With the bypass, a flag-setting EX instruction is visible to ID this cycle
  assign flags_eff = ((FWD_EX != 0) && flag_wr) ? alu_flags : flags_reg;

  // Only a B.cond behind a flag-setter must wait, and only without the bypass
  assign need_stall = (FWD_EX == 0) && flag_wr && (kind == BR_COND);

  cond_eval u_cond_eval (
    .cond  (cond_t'(id_cond)),
    .flags (flags_eff),
    .taken (cond_taken)
  );

  // Decision per branch kind; CBZ/CBNZ depend on the register, not the flags
  always_comb begin
    kind_taken = 1'b0;
    case (kind)
      BR_B:    kind_taken = 1'b1;
      BR_COND: kind_taken = cond_taken;
      BR_CBZ:  kind_taken = id_rt_zero;
      BR_CBNZ: kind_taken = !id_rt_zero;
      default: kind_taken = 1'b0;
    endcase
  end

  // Architectural flags: commit on every valid flag-setter, independent of stall/flush
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= 4'b0000;
    end else if (flag_wr) begin
      flags_reg <= alu_flags;
    end
  end

  assign flags_q = flags_reg;

  // State register plus a one-cycle marker that keeps outputs quiet right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      post_reset_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      post_reset_reg <= 1'b0;
    end
  end

  // Next-state: enter WAIT on a stalled B.cond; flush always returns to IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!flush && !post_reset_reg && id_br_valid && need_stall) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (!flag_wr) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs: resolve combinationally in IDLE, or in WAIT once flags have settled
  always_comb begin
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    stall       = 1'b0;
    if (!reset && !post_reset_reg && !flush) begin
      case (state_reg)
        ST_IDLE: begin
          if (id_br_valid) begin
            if (need_stall) begin
              stall = 1'b1;
            end else begin
              br_resolved = 1'b1;
              br_taken    = kind_taken;
            end
          end
        end
        ST_WAIT: begin
          if (flag_wr) begin
            stall = 1'b1;
          end else begin
            br_resolved = 1'b1;
            br_taken    = kind_taken;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed bench: one bypass instance and one stalling instance share all stimulus.
module tb_flag_cond_unit;
  import lgv8_br_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid, ex_set_flags;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       id_br_valid;
  logic [1:0] id_br_kind;
  logic [3:0] id_cond;
  logic       id_rt_zero;
  logic       flush;

  logic       f_res, f_tkn, f_stl;
  logic [3:0] f_flg;
  logic       s_res, s_tkn, s_stl;
  logic [3:0] s_flg;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(.FWD_EX(1)) u_fwd (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .id_br_valid(id_br_valid), .id_br_kind(id_br_kind),
    .id_cond(id_cond), .id_rt_zero(id_rt_zero), .flush(flush),
    .br_resolved(f_res), .br_taken(f_tkn), .stall(f_stl), .flags_q(f_flg)
  );

  flag_cond_unit #(.FWD_EX(0)) u_stl (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .alu_carry_out(alu_carry_out), .id_br_valid(id_br_valid), .id_br_kind(id_br_kind),
    .id_cond(id_cond), .id_rt_zero(id_rt_zero), .flush(flush),
    .br_resolved(s_res), .br_taken(s_tkn), .stall(s_stl), .flags_q(s_flg)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  // {resolved, taken, stall} of both instances
  task automatic chk_out(input string tag, input logic [2:0] f_exp, input logic [2:0] s_exp);
    chk({tag, "_f"}, {1'b0, f_res, f_tkn, f_stl}, {1'b0, f_exp});
    chk({tag, "_s"}, {1'b0, s_res, s_tkn, s_stl}, {1'b0, s_exp});
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk({tag, "_ff"}, f_flg, exp);
    chk({tag, "_sf"}, s_flg, exp);
  endtask

  // ALU flags given as {N,Z,C,V}
  task automatic set_ex(input logic v, input logic s, input logic [3:0] nzcv);
    ex_valid      = v;
    ex_set_flags  = s;
    alu_negative  = nzcv[3];
    alu_zero      = nzcv[2];
    alu_carry_out = nzcv[1];
    alu_overflow  = nzcv[0];
  endtask

  task automatic set_br(input logic v, input logic [1:0] kind, input logic [3:0] cond, input logic rz);
    id_br_valid = v;
    id_br_kind  = kind;
    id_cond     = cond;
    id_rt_zero  = rz;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] cond_tab [8];
  logic       exp_tab  [8];

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    set_ex(1'b0, 1'b0, 4'b0000);
    set_br(1'b1, BR_COND, COND_EQ, 1'b0);

    // Reset cycle and the cycle after: outputs silent even with a branch in ID
    @(negedge clk);
    chk_out("rst_cycle", 3'b000, 3'b000);
    next_cycle();
    reset = 1'b0;
    chk_flags("rst_flags", 4'b0000);
    @(negedge clk);
    chk_out("post_rst", 3'b000, 3'b000);

    // B.cond EQ on cleared flags: resolved, not taken
    next_cycle();
    @(negedge clk);
    chk_out("eq_zero", 3'b100, 3'b100);

    // SUBS 3-3: Z=1 C=1 alongside B.cond EQ
    next_cycle();
    set_ex(1'b1, 1'b1, 4'b0110);
    @(negedge clk);
    chk_out("subs_eq", 3'b110, 3'b001);
    next_cycle();
    set_ex(1'b0, 1'b0, 4'b0000);
    chk_flags("subs_flags", 4'b0110);
    @(negedge clk);
    chk_out("wait_res", 3'b110, 3'b110);

    // ex_set_flags without ex_valid is ignored; stalled unit back in IDLE
    next_cycle();
    set_ex(1'b0, 1'b1, 4'b1111);
    set_br(1'b0, BR_COND, COND_EQ, 1'b0);
    @(negedge clk);
    chk_out("idle_again", 3'b000, 3'b000);
    next_cycle();
    chk_flags("no_write", 4'b0110);

    // ADDS 0x5..+0x6..: N=1 V=1 C=0 Z=0
    set_ex(1'b1, 1'b1, 4'b1001);
    next_cycle();
    set_ex(1'b0, 1'b0, 4'b0000);
    chk_flags("adds_flags", 4'b1001);
    cond_tab = '{COND_GE, COND_LT, COND_HI, COND_NE, COND_LE, COND_AL, COND_VS, COND_PL};
    exp_tab  = '{1'b1,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1,    1'b0};
    for (int i = 0; i < 8; i++) begin
      set_br(1'b1, BR_COND, cond_tab[i], 1'b0);
      @(negedge clk);
      chk_out($sformatf("cond_%h", cond_tab[i]), {1'b1, exp_tab[i], 1'b0}, {1'b1, exp_tab[i], 1'b0});
      next_cycle();
    end

    // CBNZ while EX sets flags: never stalls
    set_br(1'b1, BR_CBNZ, COND_EQ, 1'b0);
    set_ex(1'b1, 1'b1, 4'b0000);
    @(negedge clk);
    chk_out("cbnz_ex", 3'b110, 3'b110);
    next_cycle();
    set_ex(1'b0, 1'b0, 4'b0000);
    chk_flags("cbnz_flags", 4'b0000);
    set_br(1'b1, BR_CBZ, COND_EQ, 1'b0);
    @(negedge clk);
    chk_out("cbz_nz", 3'b100, 3'b100);
    next_cycle();
    set_br(1'b1, BR_B, COND_NE, 1'b0);
    @(negedge clk);
    chk_out("b_uncond", 3'b110, 3'b110);

    // Flush while waiting drops the branch
    next_cycle();
    set_br(1'b1, BR_COND, COND_EQ, 1'b0);
    set_ex(1'b1, 1'b1, 4'b0100);
    @(negedge clk);
    chk_out("pre_flush", 3'b110, 3'b001);
    next_cycle();
    set_ex(1'b0, 1'b0, 4'b0000);
    flush = 1'b1;
    @(negedge clk);
    chk_out("flush_wait", 3'b000, 3'b000);
    next_cycle();
    flush = 1'b0;
    set_br(1'b0, BR_COND, COND_EQ, 1'b0);
    @(negedge clk);
    chk_out("after_flush", 3'b000, 3'b000);

    // Repeated flag writes keep WAIT; reset there clears everything
    next_cycle();
    set_br(1'b1, BR_COND, COND_EQ, 1'b0);
    set_ex(1'b1, 1'b1, 4'b1000);
    @(negedge clk);
    chk_out("wait_enter", 3'b100, 3'b001);
    next_cycle();
    set_ex(1'b1, 1'b1, 4'b0100);
    chk_flags("wait_flags", 4'b1000);
    @(negedge clk);
    chk_out("wait_hold", 3'b110, 3'b001);
    next_cycle();
    set_ex(1'b0, 1'b0, 4'b0000);
    reset = 1'b1;
    @(negedge clk);
    chk_out("rst_in_wait", 3'b000, 3'b000);
    next_cycle();
    reset = 1'b0;
    set_br(1'b0, BR_COND, COND_EQ, 1'b0);
    chk_flags("rst_wait_fl", 4'b0000);
    @(negedge clk);
    chk_out("rst_wait_p1", 3'b000, 3'b000);
    next_cycle();
    @(negedge clk);
    chk_out("rst_wait_idle", 3'b000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
